// File: rtl/serpent_lt_pipe.sv
// serpent_lt_pipe: pipelined multi-lane Serpent linear transform, forward and inverse, with valid/ready flow control
module serpent_lt_pipe #(
  parameter int LANES = 1,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_in_ready,
  input  logic                   i_inv,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic [128*LANES-1:0]   i_data,
  output logic                   o_valid,
  input  logic                   i_out_ready,
  output logic [TAG_W-1:0]       o_tag,
  output logic [128*LANES-1:0]   o_data,
  output logic                   o_busy
);
  localparam int W = 128 * LANES;
  localparam int P = PIPE_STAGES;
  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [127:0] phase_a(input logic [127:0] x, input logic inv);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = x;
    if (inv) begin
      x2 = ror(x2, 22);
      x0 = ror(x0, 5);
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = x0 ^ x1 ^ x3;
    end else begin
      x0 = rol(x0, 13);
      x2 = rol(x2, 3);
      x1 = x1 ^ x0 ^ x2;
      x3 = x3 ^ x2 ^ (x0 << 3);
    end
    return {x0, x1, x2, x3};
  endfunction
  function automatic logic [127:0] phase_b(input logic [127:0] x, input logic inv);
    logic [31:0] x0, x1, x2, x3;
    {x0, x1, x2, x3} = x;
    if (inv) begin
      x3 = ror(x3, 7);
      x1 = ror(x1, 1);
      x3 = x3 ^ x2 ^ (x0 << 3);
      x1 = x1 ^ x0 ^ x2;
      x2 = ror(x2, 3);
      x0 = ror(x0, 13);
    end else begin
      x1 = rol(x1, 1);
      x3 = rol(x3, 7);
      x0 = x0 ^ x1 ^ x3;
      x2 = x2 ^ x3 ^ (x1 << 7);
      x0 = rol(x0, 5);
      x2 = rol(x2, 22);
    end
    return {x0, x1, x2, x3};
  endfunction
  logic [P-1:0] v, m, vin, min, rdy;
  logic [W-1:0] d [P];
  logic [W-1:0] din [P];
  logic [TAG_W-1:0] t [P];
  logic [TAG_W-1:0] tin [P];
  logic [W-1:0] a_out, b_src, b_out;
  logic b_inv, full;
  always_comb begin
    a_out = '0;
    b_out = '0;
    vin = '0;
    min = '0;
    rdy = '0;
    full = 1'b1;
    din = '{default: '0};
    tin = '{default: '0};
    for (int k = 0; k < LANES; k++)
      a_out[128*k +: 128] = phase_a(i_data[128*k +: 128], i_inv);
    b_src = (P == 1) ? a_out : d[0];
    b_inv = (P == 1) ? i_inv : m[0];
    for (int k = 0; k < LANES; k++)
      b_out[128*k +: 128] = phase_b(b_src[128*k +: 128], b_inv);
    vin[0] = i_valid;
    min[0] = i_inv;
    tin[0] = i_tag;
    din[0] = (P == 1) ? b_out : a_out;
    for (int s = 1; s < P; s++) begin
      vin[s] = v[s-1];
      min[s] = m[s-1];
      tin[s] = t[s-1];
      din[s] = (s == 1) ? b_out : d[s-1];
    end
    for (int s = P - 1; s >= 0; s--) begin
      full = full & v[s];
      rdy[s] = i_out_ready | !full;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v <= '0;
      m <= '0;
      d <= '{default: '0};
      t <= '{default: '0};
    end else begin
      for (int s = 0; s < P; s++) begin
        if (rdy[s]) v[s] <= vin[s];
        if (rdy[s] && vin[s]) begin
          d[s] <= din[s];
          t[s] <= tin[s];
          m[s] <= min[s];
        end
      end
    end
  end
  assign o_in_ready = i_rst_n & rdy[0];
  assign o_valid = v[P-1];
  assign o_data = d[P-1];
  assign o_tag = t[P-1];
  assign o_busy = |v;
endmodule

// File: tb/tb_serpent_lt_pipe.sv
// tb_serpent_lt_pipe: directed self-checking bench for serpent_lt_pipe (1-lane/2-stage and 2-lane/3-stage instances)
module tb_serpent_lt_pipe;
  localparam logic [127:0] VA = 128'h00000001_00000000_00000000_00000000;
  localparam logic [127:0] IA = 128'h100C0000_00004000_00002800_00800000;
  localparam logic [127:0] VB = 128'h00000000_00000000_00000000_00000001;
  localparam logic [127:0] IB = 128'h00001000_00000000_20000000_00000080;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic valid, in_ready, inv, o_valid, out_ready, busy;
  logic [7:0] tag, o_tag;
  logic [127:0] data, o_data;
  logic valid2, in_ready2, inv2, o_valid2, out_ready2, busy2;
  logic [7:0] tag2, o_tag2;
  logic [255:0] data2, o_data2;
  int vectors = 0;
  int errors = 0;
  serpent_lt_pipe #(.LANES(1), .PIPE_STAGES(2), .TAG_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_in_ready(in_ready), .i_inv(inv),
    .i_tag(tag), .i_data(data), .o_valid(o_valid), .i_out_ready(out_ready),
    .o_tag(o_tag), .o_data(o_data), .o_busy(busy)
  );
  serpent_lt_pipe #(.LANES(2), .PIPE_STAGES(3), .TAG_W(8)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid2), .o_in_ready(in_ready2), .i_inv(inv2),
    .i_tag(tag2), .i_data(data2), .o_valid(o_valid2), .i_out_ready(out_ready2),
    .o_tag(o_tag2), .o_data(o_data2), .o_busy(busy2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    valid = 0; inv = 0; tag = 0; data = '0; out_ready = 1;
    valid2 = 0; inv2 = 0; tag2 = 0; data2 = '0; out_ready2 = 1;
    rst_n = 0;
    tick;
    tick;
    vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    vectors++; if (o_tag !== 8'h00) begin errors++; $display("FAIL rst_tag got %h exp 00", o_tag); end
    vectors++; if (o_data !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", o_data); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    rst_n = 1;
    tick;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
  endtask
  task automatic test_forward;
    valid = 1; inv = 0; tag = 8'h3C; data = VA;
    tick;
    valid = 0; data = IB; tag = 8'hFF;
    vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fwd_early got %b exp 0", o_valid); end
    tick;
    vectors++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid got %b exp 1", o_valid); end
    vectors++; if (o_data !== IA) begin errors++; $display("FAIL fwd_data got %h exp %h", o_data, IA); end
    vectors++; if (o_tag !== 8'h3C) begin errors++; $display("FAIL fwd_tag got %h exp 3c", o_tag); end
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL fwd_busy got %b exp 1", busy); end
    tick;
    vectors++; if (o_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL fwd_drain got v=%b b=%b exp 0 0", o_valid, busy); end
  endtask
  task automatic test_inverse;
    valid = 1; inv = 1; tag = 8'hA5; data = IA;
    tick;
    valid = 0; data = VB; inv = 0;
    tick;
    vectors++; if (o_valid !== 1'b1) begin errors++; $display("FAIL inv_valid got %b exp 1", o_valid); end
    vectors++; if (o_data !== VA) begin errors++; $display("FAIL inv_data got %h exp %h", o_data, VA); end
    vectors++; if (o_tag !== 8'hA5) begin errors++; $display("FAIL inv_tag got %h exp a5", o_tag); end
    tick;
  endtask
  task automatic test_back_to_back;
    logic [127:0] src [4];
    logic [127:0] exp_d [4];
    int rx;
    src = '{VA, IA, VB, IB};
    exp_d = '{IA, VA, IB, VB};
    rx = 0;
    for (int c = 0; c < 20; c++) begin
      tick;
      if (o_valid) begin
        vectors++;
        if (rx >= 16) begin
          errors++; $display("FAIL b2b_extra got tag %h exp none", o_tag);
        end else if (o_tag !== 8'(16 + rx) || o_data !== exp_d[rx % 4] || c !== rx + 2) begin
          errors++; $display("FAIL b2b_beat%0d got tag %h data %h cyc %0d exp tag %h data %h cyc %0d", rx, o_tag, o_data, c, 8'(16 + rx), exp_d[rx % 4], rx + 2);
        end
        rx++;
      end
      if (c < 16) begin
        valid = 1; inv = (c % 2 == 1); tag = 8'(16 + c); data = src[c % 4];
      end else valid = 0;
    end
    vectors++; if (rx !== 16) begin errors++; $display("FAIL b2b_count got %0d exp 16", rx); end
  endtask
  task automatic test_stall;
    logic [127:0] exp_d [3];
    int rx;
    exp_d = '{IA, VA, IB};
    out_ready = 0;
    valid = 1; inv = 0; tag = 8'h20; data = VA;
    tick;
    inv = 1; tag = 8'h21; data = IA;
    tick;
    inv = 0; tag = 8'h22; data = VB;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (in_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== IA || o_tag !== 8'h20 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got rdy=%b v=%b tag=%h data=%h busy=%b exp 0 1 20 %h 1", k, in_ready, o_valid, o_tag, o_data, busy, IA);
      end
      tick;
    end
    out_ready = 1;
    rx = 0;
    for (int k = 0; k < 8; k++) begin
      if (o_valid) begin
        vectors++;
        if (rx >= 3) begin
          errors++; $display("FAIL stall_extra got tag %h exp none", o_tag);
        end else if (o_tag !== 8'(32 + rx) || o_data !== exp_d[rx]) begin
          errors++; $display("FAIL stall_beat%0d got tag %h data %h exp tag %h data %h", rx, o_tag, o_data, 8'(32 + rx), exp_d[rx]);
        end
        rx++;
      end
      tick;
      if (k == 0) valid = 0;
    end
    vectors++; if (rx !== 3) begin errors++; $display("FAIL stall_count got %0d exp 3", rx); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b exp 0", busy); end
  endtask
  task automatic test_reset_midstream;
    out_ready = 0;
    valid = 1; inv = 0; tag = 8'h30; data = VA;
    tick;
    tag = 8'h31; data = VB;
    tick;
    valid = 0;
    rst_n = 0;
    tick;
    vectors++; if (o_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst got v=%b b=%b exp 0 0", o_valid, busy); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", in_ready); end
    rst_n = 1;
    out_ready = 1;
    tick;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got %b exp 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b exp 0", k, o_valid); end
      tick;
    end
  endtask
  task automatic test_lanes;
    logic [255:0] src [3];
    logic [255:0] exp_d [3];
    logic mode [3];
    src = '{{VB, VA}, {IB, IA}, {128'h0, VA}};
    exp_d = '{{IB, IA}, {VB, VA}, {128'h0, IA}};
    mode = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      valid2 = 1; inv2 = mode[i]; tag2 = 8'(80 + i); data2 = src[i];
      tick;
      valid2 = 0;
      tick;
      vectors++; if (o_valid2 !== 1'b0) begin errors++; $display("FAIL lanes%0d_early got %b exp 0", i, o_valid2); end
      tick;
      vectors++; if (o_valid2 !== 1'b1 || o_tag2 !== 8'(80 + i)) begin errors++; $display("FAIL lanes%0d_vt got v=%b tag=%h exp 1 %h", i, o_valid2, o_tag2, 8'(80 + i)); end
      vectors++; if (o_data2[127:0] !== exp_d[i][127:0]) begin errors++; $display("FAIL lanes%0d_l0 got %h exp %h", i, o_data2[127:0], exp_d[i][127:0]); end
      vectors++; if (o_data2[255:128] !== exp_d[i][255:128]) begin errors++; $display("FAIL lanes%0d_l1 got %h exp %h", i, o_data2[255:128], exp_d[i][255:128]); end
      tick;
    end
  endtask
  task automatic test_round_trip;
    logic [255:0] orig, fwd;
    int w;
    for (int n = 0; n < 1000; n++) begin
      for (int j = 0; j < 8; j++) orig[32*j +: 32] = $urandom();
      valid2 = 1; inv2 = 0; tag2 = 8'(n); data2 = orig;
      tick;
      valid2 = 0;
      w = 0;
      while (!o_valid2 && w < 10) begin tick; w++; end
      fwd = o_data2;
      tick;
      valid2 = 1; inv2 = 1; tag2 = 8'(n + 1); data2 = fwd;
      tick;
      valid2 = 0;
      w = 0;
      while (!o_valid2 && w < 10) begin tick; w++; end
      vectors++;
      if (o_valid2 !== 1'b1 || o_data2 !== orig || o_tag2 !== 8'(n + 1)) begin
        errors++; $display("FAIL rt%0d got v=%b tag=%h data=%h exp 1 %h %h", n, o_valid2, o_tag2, o_data2, 8'(n + 1), orig);
      end
      tick;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_forward;
    test_inverse;
    test_back_to_back;
    test_stall;
    test_reset_midstream;
    test_lanes;
    test_round_trip;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
